// File: rtl/add_sub_accumulator.sv
// Accumulator sequencer around an external 8-bit adder/subtractor: one LOAD/ADD/SUB/CLR per Start.
// Optional clamping of signed overflow is enabled by defining ACC_SATURATE_EN.
//
// state | meaning
// IDLE  | waiting for Start; Sub/InB hold their last values
// EXEC  | InA/InB stable so the external AddSubResult settles
// WRITE | result committed at the closing edge, Done pulses after it
module add_sub_accumulator #(
  parameter int                 WIDTH    = 8,
  parameter logic [WIDTH-1:0]   ACC_INIT = '0
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Data,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Acc,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow,
  output logic             Sub,
  output logic [WIDTH-1:0] InA,
  output logic [WIDTH-1:0] InB,
  input  logic [WIDTH-1:0] AddSubResult
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opnd_q;
  logic             sub_q;
  logic             done_q;
  logic             ovf_q;
  logic             accept;
  logic             ovf_now;
  logic [WIDTH-1:0] wr_val;

  // The completing edge doubles as an acceptance edge, so a held Start gives
  // a new command every two cycles.
  assign accept = Start && ((state == ST_IDLE) || (state == ST_WRITE));

  always_comb begin
    ovf_now = 1'b0;
    if (op_q == OP_ADD)
      ovf_now = (acc_q[WIDTH-1] == opnd_q[WIDTH-1]) && (AddSubResult[WIDTH-1] != acc_q[WIDTH-1]);
    else if (op_q == OP_SUB)
      ovf_now = (acc_q[WIDTH-1] != opnd_q[WIDTH-1]) && (AddSubResult[WIDTH-1] != acc_q[WIDTH-1]);
    wr_val = AddSubResult;
`ifdef ACC_SATURATE_EN
    if (ovf_now)
      wr_val = {acc_q[WIDTH-1], {(WIDTH-1){~acc_q[WIDTH-1]}}};
`else
`endif
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state  <= ST_IDLE;
      op_q   <= OP_LOAD;
      acc_q  <= ACC_INIT;
      opnd_q <= '0;
      sub_q  <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q   <= Op;
        opnd_q <= Data;
        sub_q  <= (Op == OP_SUB);
      end
      case (state)
        ST_IDLE: begin
          if (accept)
            state <= ST_EXEC;
        end
        ST_EXEC: begin
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          case (op_q)
            OP_LOAD: begin
              acc_q <= opnd_q;
              ovf_q <= 1'b0;
            end
            OP_ADD, OP_SUB: begin
              acc_q <= wr_val;
              ovf_q <= ovf_now;
            end
            default: begin
              acc_q <= ACC_INIT;
              ovf_q <= 1'b0;
            end
          endcase
          done_q <= 1'b1;
          state  <= accept ? ST_EXEC : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy     = (state != ST_IDLE);
  assign Done     = done_q;
  assign Acc      = acc_q;
  assign Zero     = (acc_q == '0);
  assign Negative = acc_q[WIDTH-1];
  assign Overflow = ovf_q;
  assign Sub      = sub_q;
  assign InA      = acc_q;
  assign InB      = opnd_q;

endmodule

// File: tb/tb_add_sub_accumulator.sv
// Bench for add_sub_accumulator: stands in for the adder/subtractor and checks against a
// command-level model using signed integer arithmetic.
module tb_add_sub_accumulator;

  localparam logic [7:0] ACC_INIT = 8'd0;

  logic       Clock = 1'b0;
  logic       nReset;
  logic       Start = 1'b0;
  logic [1:0] Op    = 2'd0;
  logic [7:0] Data  = 8'd0;
  logic       Busy, Done, Zero, Negative, Overflow, Sub;
  logic [7:0] Acc, InA, InB, AddSubResult;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  add_sub_accumulator #(.WIDTH(8), .ACC_INIT(ACC_INIT)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .Op(Op), .Data(Data),
    .Busy(Busy), .Done(Done), .Acc(Acc), .Zero(Zero), .Negative(Negative),
    .Overflow(Overflow), .Sub(Sub), .InA(InA), .InB(InB), .AddSubResult(AddSubResult)
  );

  // External adder/subtractor, purely combinational and wrapping.
  assign AddSubResult = Sub ? (InA - InB) : (InA + InB);

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Command-level model: a command accepted at one edge completes two edges later.
  logic [7:0] m_acc  = ACC_INIT;
  logic [7:0] m_inb  = 8'd0;
  logic       m_ovf  = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_sub  = 1'b0;
  logic [1:0] m_op   = 2'd0;
  int         m_left = 0;

  always @(posedge Clock or negedge nReset) begin
    int s;
    if (!nReset) begin
      m_acc = ACC_INIT; m_inb = 8'd0; m_ovf = 1'b0; m_busy = 1'b0;
      m_done = 1'b0; m_sub = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          case (m_op)
            2'd0: begin m_acc = m_inb; m_ovf = 1'b0; end
            2'd3: begin m_acc = ACC_INIT; m_ovf = 1'b0; end
            default: begin
              if (m_op == 2'd1) s = int'($signed(m_acc)) + int'($signed(m_inb));
              else              s = int'($signed(m_acc)) - int'($signed(m_inb));
              m_ovf = (s > 127) || (s < -128);
`ifdef ACC_SATURATE_EN
              if (s > 127)       m_acc = 8'h7F;
              else if (s < -128) m_acc = 8'h80;
              else               m_acc = 8'(s);
`else
              m_acc = 8'(s);
`endif
            end
          endcase
        end
      end
      if (!m_busy && Start) begin
        m_busy = 1'b1;
        m_left = 2;
        m_op   = Op;
        m_inb  = Data;
        m_sub  = (Op == 2'd2);
      end
    end
  end

  always @(negedge Clock) begin
    if (chk_en)
      check("cycle {busy,done,ovf,zero,neg,sub,ina,inb,acc}",
            {3'd0, Busy, Done, Overflow, Zero, Negative, Sub, InA, InB, Acc},
            {3'd0, m_busy, m_done, m_ovf, (m_acc == 8'd0), m_acc[7], m_sub, m_acc, m_inb, m_acc});
  end

  // Entered and left at a falling edge with the DUT idle.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input string name);
    Start = 1'b1; Op = op; Data = d;
    @(negedge Clock);
    Start = 1'b0;
    check({name, " exec busy"}, Busy, 1);
    check({name, " exec sub"}, Sub, (op == 2'd2));
    @(negedge Clock);
    check({name, " no early done"}, Done, 0);
    @(negedge Clock);
    check({name, " done at N+2"}, Done, 1);
  endtask

  initial begin
    int done_cnt;
    nReset = 1'b0;
    repeat (2) @(negedge Clock);
    chk_en = 1'b1;
    check("reset acc", Acc, ACC_INIT);
    check("reset flags {busy,done,ovf,zero,neg,sub}",
          {Busy, Done, Overflow, Zero, Negative, Sub}, 6'b000100);
    check("reset inb", InB, 0);
    nReset = 1'b1;
    @(negedge Clock);

    run_cmd(2'd0, 8'd10, "load10");
    run_cmd(2'd1, 8'd5, "add5");
    check("add5 acc", Acc, 15);
    check("add5 model acc", m_acc, 15);
    check("add5 zero/ovf", {Zero, Overflow}, 2'b00);

    run_cmd(2'd0, 8'd3, "load3");
    run_cmd(2'd2, 8'd3, "sub3");
    check("sub3 acc", Acc, 0);
    check("sub3 zero/neg", {Zero, Negative}, 2'b10);

    run_cmd(2'd0, 8'd1, "load1");
    run_cmd(2'd2, 8'd2, "sub2");
    check("sub2 acc", Acc, 8'hFF);
    check("sub2 model acc", m_acc, 8'hFF);
    check("sub2 neg/ovf", {Negative, Overflow}, 2'b10);

    run_cmd(2'd0, 8'h7F, "load7f");
    run_cmd(2'd1, 8'd1, "add1");
`ifdef ACC_SATURATE_EN
    check("7f+1 acc", Acc, 8'h7F);
    check("7f+1 model acc", m_acc, 8'h7F);
`else
    check("7f+1 acc", Acc, 8'h80);
    check("7f+1 model acc", m_acc, 8'h80);
`endif
    check("7f+1 ovf", Overflow, 1);

    // Second Start during EXEC with new Data must be ignored.
    run_cmd(2'd0, 8'd10, "load10b");
    Start = 1'b1; Op = 2'd1; Data = 8'd4;
    @(negedge Clock);
    Op = 2'd2; Data = 8'd99;
    @(negedge Clock);
    Start = 1'b0;
    done_cnt = 0;
    repeat (5) begin
      @(negedge Clock);
      if (Done) done_cnt++;
    end
    check("busy-start acc", Acc, 14);
    check("busy-start done count", done_cnt, 1);

    // Reset during EXEC of ADD 5.
    Start = 1'b1; Op = 2'd1; Data = 8'd5;
    @(negedge Clock);
    Start = 1'b0;
    #2 nReset = 1'b0;
    #1;
    check("mid reset acc", Acc, ACC_INIT);
    check("mid reset busy/done", {Busy, Done}, 2'b00);
    @(negedge Clock);
    nReset = 1'b1;
    done_cnt = 0;
    repeat (3) begin
      @(negedge Clock);
      if (Done) done_cnt++;
    end
    check("aborted cmd no done", done_cnt, 0);
    run_cmd(2'd0, 8'd9, "load9");
    check("load9 acc", Acc, 9);

    // Randomized traffic; per-cycle compare process does the checking.
    repeat (600) begin
      Start = ($urandom_range(0, 9) < 5);
      Op    = 2'($urandom_range(0, 3));
      Data  = 8'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #2 nReset = 1'b0;
        #1 nReset = 1'b1;
      end
      @(negedge Clock);
    end
    Start = 1'b0;
    repeat (3) @(negedge Clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/add_sub_accumulator.md
Name: add_sub_accumulator

Overview:
- Sequencing/accumulate stage that wraps the 8-bit adder/subtractor datapath block.
- Drives that block's Sub, InA and InB inputs, and consumes its 8-bit Output on the AddSubResult input.
- Holds a two's-complement accumulator and executes one LOAD/ADD/SUB/CLR command per Start handshake.
- Raises status flags and a one-cycle Done pulse when the command completes.

Parameters:
- WIDTH, 8, datapath width. Must equal the adder/subtractor width; only 8 is supported.
- ACC_INIT, 8'd0, accumulator value after reset and after CLR.

Ports:
- Clock  input  1  rising-edge clock
- nReset  input  1  asynchronous active-low reset
- Start  input  1  command request, sampled only in IDLE
- Op  input  2  command: 00 LOAD, 01 ADD, 10 SUB, 11 CLR
- Data  input  WIDTH  command operand
- Busy  output  1  high while a command is in progress
- Done  output  1  one-cycle completion pulse
- Acc  output  WIDTH  accumulator contents
- Zero  output  1  Acc == 0
- Negative  output  1  Acc[WIDTH-1]
- Overflow  output  1  signed overflow of the last ADD/SUB
- Sub  output  1  to adder/subtractor: 0 add, 1 subtract
- InA  output  WIDTH  to adder/subtractor: always Acc
- InB  output  WIDTH  to adder/subtractor: latched operand register
- AddSubResult  input  WIDTH  from adder/subtractor Output, combinational

Behaviour:
- Reset (asynchronous, nReset=0):
  - State = IDLE; Acc = ACC_INIT; operand register = 0; Sub = 0.
  - Busy, Done and Overflow = 0.
  - Zero and Negative reflect ACC_INIT.
  - Reset takes effect immediately, including mid-command. The aborted command has no effect and no Done is produced.
- FSM states: IDLE, EXEC, WRITE.
- IDLE:
  - On Start=1 at a rising edge: latch Op and Data into internal registers.
  - Set Sub = (Op==SUB); Busy = 1; go to EXEC.
  - Start=0: stay in IDLE.
- EXEC:
  - One cycle. InA = Acc and InB = operand register are held stable, so AddSubResult settles.
  - Go to WRITE unconditionally.
- WRITE, at the rising edge:
  - LOAD: Acc <= operand; Overflow <= 0.
  - ADD/SUB: Acc <= AddSubResult.
  - ADD: Overflow <= (A[7]==B[7]) && (R[7]!=A[7]).
  - SUB: Overflow <= (A[7]!=B[7]) && (R[7]!=A[7]).
  - CLR: Acc <= ACC_INIT; Overflow <= 0.
  - Done = 1 for exactly this one cycle after the edge; Busy <= 0; return to IDLE.
- Latency: Start sampled at edge N. Acc, flags and Done update at edge N+2. Next command is accepted at edge N+2 at the earliest (Start held high gives back-to-back commands every 2 cycles).
- Start while Busy=1 is ignored. Op/Data changes during Busy have no effect (both are latched).
- Arithmetic wraps modulo 2^WIDTH; no carry out is kept.
- Zero and Negative are combinational from Acc, so they are valid whenever Acc is.
- Overflow holds its value until the next completed command.
- Sub and InB hold their last values in IDLE.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: on ADD/SUB signed overflow, Acc is clamped instead of wrapping.
  - Clamp to 8'h7F if A[7]==0, to 8'h80 if A[7]==1.
  - Overflow is still set to 1.
- Undefined: result wraps (plain AddSubResult is written); Overflow still reports the event.

Test Plan:
- Reset, then LOAD Data=10, then ADD Data=5 -> Done pulses at edges N+2 each time; Acc=15, Zero=0, Overflow=0.
- LOAD 3, then SUB 3 -> Acc=0, Zero=1, Negative=0; Sub=1 seen on adder port during EXEC.
- LOAD 1, then SUB 2 -> Acc=8'hFF, Negative=1, Overflow=0.
- LOAD 8'h7F, then ADD 1:
  - without macro: Acc=8'h80, Overflow=1.
  - with ACC_SATURATE_EN: Acc=8'h7F, Overflow=1.
- Start pulsed again while Busy, with Data changed mid-command -> second request ignored; result uses the originally latched Data; exactly one Done.
- nReset asserted during EXEC of ADD 5 -> immediate Acc=ACC_INIT, Busy=0; no Done; next LOAD 9 completes normally with Acc=9.
